// File: rtl/if_pkg.sv
// if_pkg: shared default widths, fetch entry type and queue pointer sizing
package if_pkg;
    localparam int IF_ADDR_W_DEF = 32;
    localparam int IF_DATA_W_DEF = 32;
    localparam int IF_PC_INC_DEF = 4;

    typedef struct packed {
        logic [IF_ADDR_W_DEF-1:0] addr;
        logic [IF_DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: power-of-two FIFO of fetch entries; flush beats push, same-cycle pop is honoured
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  entry_t                din,
    output logic [ptr_w(DEPTH):0] count,
    output entry_t                head
);
    localparam int PW = ptr_w(DEPTH);

    entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC + sequential fetch from 1-cycle imem, redirect/flush, buffered valid/ready output
// Optional perf counters (o_fetch_count, o_redirect_count) when IF_PERF_EN is defined.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int                ADDR_W    = IF_ADDR_W_DEF,
    parameter int                DATA_W    = IF_DATA_W_DEF,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_INC    = IF_PC_INC_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_instruccion
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       o_fetch_count,
    output logic [31:0]       o_redirect_count
`endif
);
    localparam int PW = ptr_w(BUF_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc, req_addr;
    logic              outstanding, kill, pop, push;
    logic [PW:0]       count;
    logic [PW+1:0]     used;
    entry_t            din, head;

    assign o_valid       = count != '0;
    assign pop           = o_valid & i_ready;
    assign push          = outstanding & ~kill;
    // Credit: queued + in-flight entries, net of this cycle's pop, must leave room
    assign used          = (PW+2)'(count) + (PW+2)'(outstanding) - (PW+2)'(pop);
    assign o_imem_req    = ~i_reset & ~i_redirect & (used < (PW+2)'(BUF_DEPTH));
    assign o_imem_addr   = pc;
    assign din           = '{addr: req_addr, instr: i_imem_rdata};
    assign o_address     = o_valid ? head.addr : '0;
    assign o_instruccion = o_valid ? head.instr : '0;

    if_fetch_queue #(.DEPTH(BUF_DEPTH), .entry_t(entry_t)) u_queue (
        .clk  (i_clock),
        .rst  (i_reset),
        .push (push),
        .pop  (pop),
        .flush(i_redirect),
        .din  (din),
        .count(count),
        .head (head)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            kill        <= 1'b0;
        end else begin
            outstanding <= o_imem_req;
            kill        <= i_redirect;
            pc          <= i_redirect ? i_redirect_addr & ~ADDR_W'(PC_INC - 1)
                         : o_imem_req ? pc + ADDR_W'(PC_INC) : pc;
        end
        if (o_imem_req) req_addr <= pc;
    end

`ifdef IF_PERF_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_fetch_count    <= '0;
            o_redirect_count <= '0;
        end else begin
            o_fetch_count    <= o_fetch_count + 32'(pop);
            o_redirect_count <= o_redirect_count + 32'(i_redirect);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch streaming, stall, redirect, reset and PC wrap
module tb_if_fetch_stage;
    logic        clk = 1'b0, rst = 1'b1, redirect = 1'b0, ready = 1'b1;
    logic [31:0] redirect_addr = '0, rdata = '0, w_rdata = '0;
    logic        req, valid, w_req, w_valid;
    logic [31:0] iaddr, address, instr, w_iaddr, w_address, w_instr;
`ifdef IF_PERF_EN
    logic [31:0] fetch_count, redirect_count, w_fetch_count, w_redirect_count;
`endif
    int errors = 0, checks = 0;

    if_fetch_stage dut (
        .i_clock(clk), .i_reset(rst), .i_redirect(redirect), .i_redirect_addr(redirect_addr),
        .o_imem_req(req), .o_imem_addr(iaddr), .i_imem_rdata(rdata),
        .o_valid(valid), .i_ready(ready), .o_address(address), .o_instruccion(instr)
`ifdef IF_PERF_EN
        , .o_fetch_count(fetch_count), .o_redirect_count(redirect_count)
`endif
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .i_clock(clk), .i_reset(rst), .i_redirect(1'b0), .i_redirect_addr(32'h0),
        .o_imem_req(w_req), .o_imem_addr(w_iaddr), .i_imem_rdata(w_rdata),
        .o_valid(w_valid), .i_ready(1'b1), .o_address(w_address), .o_instruccion(w_instr)
`ifdef IF_PERF_EN
        , .o_fetch_count(w_fetch_count), .o_redirect_count(w_redirect_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata   <= iaddr ^ 32'hFFFF_0000;
        w_rdata <= w_iaddr ^ 32'hFFFF_0000;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.u_queue.push && dut.u_queue.count == 2 && !dut.u_queue.pop && !dut.u_queue.flush) begin
                errors++;
                $display("FAIL overflow: push into full queue, count=%0d required<2", dut.u_queue.count);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset;
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        ready = 1'b1;
        hold_reset();
        #1;
        checks += 4;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req); end
        if (address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", address); end
        if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    endtask

    task automatic test_stream;
        logic [31:0] ea;
        hold_reset();
        rst = 1'b0;
        ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            ea = 32'((c - 2) * 4);
            checks += 3;
            if (req !== 1'b1) begin errors++; $display("FAIL stream_req c=%0d got %b want 1", c, req); end
            if (iaddr !== 32'(c * 4)) begin errors++; $display("FAIL stream_iaddr c=%0d got %h want %h", c, iaddr, 32'(c * 4)); end
            if (valid !== (c >= 2)) begin errors++; $display("FAIL stream_valid c=%0d got %b want %b", c, valid, c >= 2); end
            if (c >= 2) begin
                checks += 2;
                if (address !== ea) begin errors++; $display("FAIL stream_addr c=%0d got %h want %h", c, address, ea); end
                if (instr !== (ea ^ 32'hFFFF_0000)) begin errors++; $display("FAIL stream_instr c=%0d got %h want %h", c, instr, ea ^ 32'hFFFF_0000); end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] ea;
        hold_reset();
        rst = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) tick();
            ready = (c < 2) || (c >= 7);
            #1;
            ea = (c < 7) ? 32'h0 : 32'((c - 7) * 4);
            checks += 2;
            if (req !== ((c < 2) || (c >= 7))) begin errors++; $display("FAIL stall_req c=%0d got %b want %b", c, req, (c < 2) || (c >= 7)); end
            if (valid !== (c >= 2)) begin errors++; $display("FAIL stall_valid c=%0d got %b want %b", c, valid, c >= 2); end
            if (c >= 2) begin
                checks++;
                if (address !== ea) begin errors++; $display("FAIL stall_addr c=%0d got %h want %h", c, address, ea); end
            end
            if (c == 7) begin
                checks++;
                if (iaddr !== 32'h8) begin errors++; $display("FAIL stall_resume_iaddr got %h want 8", iaddr); end
            end
        end
    endtask

    task automatic test_redirect_full;
        hold_reset();
        rst = 1'b0;
        ready = 1'b0;
        #1;
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_addr = 32'h103;
        #1;
        checks += 2;
        if (req !== 1'b0) begin errors++; $display("FAIL redir_req_n got %b want 0", req); end
        if (address !== 32'h0) begin errors++; $display("FAIL redir_addr_n got %h want 0", address); end
        tick();
        redirect = 1'b0;
        #1;
        checks += 3;
        if (req !== 1'b1) begin errors++; $display("FAIL redir_req_n1 got %b want 1", req); end
        if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_iaddr_n1 got %h want 100", iaddr); end
        if (valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1 got %b want 0", valid); end
        tick();
        checks += 2;
        if (valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n2 got %b want 0", valid); end
        if (iaddr !== 32'h104) begin errors++; $display("FAIL redir_iaddr_n2 got %h want 104", iaddr); end
        tick();
        checks += 3;
        if (valid !== 1'b1) begin errors++; $display("FAIL redir_valid_n3 got %b want 1", valid); end
        if (address !== 32'h100) begin errors++; $display("FAIL redir_addr_n3 got %h want 100", address); end
        if (instr !== 32'hFFFF_0100) begin errors++; $display("FAIL redir_instr_n3 got %h want ffff0100", instr); end
    endtask

    task automatic test_redirect_pop;
        hold_reset();
        rst = 1'b0;
        ready = 1'b0;
        #1;
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_addr = 32'h200;
        ready = 1'b1;
        #1;
        checks += 2;
        if (valid !== 1'b1) begin errors++; $display("FAIL rpop_valid_n got %b want 1", valid); end
        if (address !== 32'h0) begin errors++; $display("FAIL rpop_addr_n got %h want 0", address); end
        tick();
        redirect = 1'b0;
        #1;
        checks += 2;
        if (valid !== 1'b0) begin errors++; $display("FAIL rpop_valid_n1 got %b want 0", valid); end
        if (iaddr !== 32'h200) begin errors++; $display("FAIL rpop_iaddr_n1 got %h want 200", iaddr); end
`ifdef IF_PERF_EN
        checks += 2;
        if (fetch_count !== 32'd1) begin errors++; $display("FAIL rpop_fetch_count got %0d want 1", fetch_count); end
        if (redirect_count !== 32'd1) begin errors++; $display("FAIL rpop_redirect_count got %0d want 1", redirect_count); end
`endif
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL rpop_valid_n2 got %b want 0", valid); end
        tick();
        checks += 2;
        if (valid !== 1'b1) begin errors++; $display("FAIL rpop_valid_n3 got %b want 1", valid); end
        if (address !== 32'h200) begin errors++; $display("FAIL rpop_addr_n3 got %h want 200", address); end
        tick();
        checks++;
        if (address !== 32'h204) begin errors++; $display("FAIL rpop_addr_n4 got %h want 204", address); end
    endtask

    task automatic test_back_to_back;
        ready = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_addr = 32'h300;
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL b2b_req_n got %b want 0", req); end
        tick();
        redirect_addr = 32'h404;
        #1;
        checks += 2;
        if (req !== 1'b0) begin errors++; $display("FAIL b2b_req_n1 got %b want 0", req); end
        if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_n1 got %b want 0", valid); end
        tick();
        redirect = 1'b0;
        #1;
        checks += 3;
        if (req !== 1'b1) begin errors++; $display("FAIL b2b_req_n2 got %b want 1", req); end
        if (iaddr !== 32'h404) begin errors++; $display("FAIL b2b_iaddr_n2 got %h want 404", iaddr); end
        if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_n2 got %b want 0", valid); end
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_n3 got %b want 0", valid); end
        tick();
        checks += 3;
        if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_n4 got %b want 1", valid); end
        if (address !== 32'h404) begin errors++; $display("FAIL b2b_addr_n4 got %h want 404", address); end
        if (instr !== 32'hFFFF_0404) begin errors++; $display("FAIL b2b_instr_n4 got %h want ffff0404", instr); end
    endtask

    task automatic test_reset_mid;
        hold_reset();
        rst = 1'b0;
        ready = 1'b1;
        #1;
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b want 0", req); end
        tick();
        rst = 1'b0;
        #1;
        checks += 3;
        if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_r1 got %b want 0", valid); end
        if (req !== 1'b1) begin errors++; $display("FAIL rmid_req_r1 got %b want 1", req); end
        if (iaddr !== 32'h0) begin errors++; $display("FAIL rmid_iaddr_r1 got %h want 0", iaddr); end
        tick();
        checks += 2;
        if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_r2 got %b want 0", valid); end
        if (iaddr !== 32'h4) begin errors++; $display("FAIL rmid_iaddr_r2 got %h want 4", iaddr); end
        tick();
        checks += 3;
        if (valid !== 1'b1) begin errors++; $display("FAIL rmid_valid_r3 got %b want 1", valid); end
        if (address !== 32'h0) begin errors++; $display("FAIL rmid_addr_r3 got %h want 0", address); end
        if (instr !== 32'hFFFF_0000) begin errors++; $display("FAIL rmid_instr_r3 got %h want ffff0000", instr); end
        tick();
        checks++;
        if (address !== 32'h4) begin errors++; $display("FAIL rmid_addr_r4 got %h want 4", address); end
    endtask

    task automatic test_wrap;
        logic [31:0] ea;
        hold_reset();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            ea = 32'hFFFF_FFF8 + 32'(c * 4);
            checks += 2;
            if (w_iaddr !== ea) begin errors++; $display("FAIL wrap_iaddr c=%0d got %h want %h", c, w_iaddr, ea); end
            if (w_valid !== (c >= 2)) begin errors++; $display("FAIL wrap_valid c=%0d got %b want %b", c, w_valid, c >= 2); end
            if (c >= 2) begin
                ea = 32'hFFFF_FFF8 + 32'((c - 2) * 4);
                checks += 2;
                if (w_address !== ea) begin errors++; $display("FAIL wrap_addr c=%0d got %h want %h", c, w_address, ea); end
                if (w_instr !== (ea ^ 32'hFFFF_0000)) begin errors++; $display("FAIL wrap_instr c=%0d got %h want %h", c, w_instr, ea ^ 32'hFFFF_0000); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
